// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the read-port arbiter.
package rd_arb_pkg;

  localparam int unsigned NPORT_C = 4;
  localparam int unsigned PIDX_W  = 2;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned BEAT_W  = 5;

  typedef logic [PIDX_W-1:0] pidx_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_CMD  = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rd_port_arbiter_rr_pick4.sv
// Rotating priority encoder: first requester after the last-granted port wins.
module rr_pick4
  import rd_arb_pkg::*;
(
  input  logic [NPORT_C-1:0] req_i,
  input  pidx_t              last_i,
  output logic [NPORT_C-1:0] win_oh_c,
  output pidx_t              win_idx_c
);

  // Scan ports last+1 .. last+4 (wrapping) and take the first one requesting.
  always_comb begin
    logic  found;
    pidx_t cand;
    win_oh_c  = '0;
    win_idx_c = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NPORT_C; i++) begin
      cand = PIDX_W'(last_i + PIDX_W'(i));
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_idx_c       = cand;
        win_oh_c[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_port_arbiter.sv
// Four-port round-robin read arbiter in front of the DDR read controller.
// Optional watchdog enabled by defining RD_ARB_TMO_EN.
module rd_port_arbiter
  import rd_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned NPORT   = 4,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORT_C-1:0]        req,
  input  logic [NPORT_C*ADDR_W-1:0] req_addr,
  input  logic [NPORT_C*LEN_W-1:0]  req_len,
  output logic [NPORT_C-1:0]        gnt,
  output logic [NPORT_C-1:0]        done,
  output logic [NPORT_C-1:0]        port_rvalid,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [LEN_W-1:0]          rd_len,
  output logic [ID_W-1:0]           rd_id,
  input  logic                      rd_done_p,
  input  logic                      axi_rvalid,
  input  logic                      axi_rlast,
  output logic                      tmo_err
);

  // Only the four-port build exists; a zero watchdog limit is meaningless.
  if (NPORT != NPORT_C || TMO_CYC == 0) begin : g_cfg_chk
    $error("rd_port_arbiter: NPORT must be 4 and TMO_CYC nonzero");
  end

  arb_state_e          state_q;
  pidx_t               win_q;
  pidx_t               last_q;
  logic [NPORT_C-1:0]  gnt_q;
  logic [NPORT_C-1:0]  done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [LEN_W-1:0]    rd_len_q;
  logic [ID_W-1:0]     rd_id_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                rlast_seen_q;
  logic                len_mismatch_q;

  logic [NPORT_C-1:0]  win_oh_c;
  pidx_t               win_idx_c;
  logic [ADDR_W-1:0]   addr_a [NPORT_C];
  logic [LEN_W-1:0]    len_a  [NPORT_C];
  logic                in_wait_c;
  logic                rlast_beat_c;
  logic                norm_fin_c;
  logic                tmo_hit_c;
  logic                fin_c;
  logic                mism_c;

  // Split the flat per-port request buses into indexable arrays.
  for (genvar p = 0; p < NPORT_C; p++) begin : g_unpack
    assign addr_a[p] = req_addr[p*ADDR_W +: ADDR_W];
    assign len_a[p]  = req_len[p*LEN_W +: LEN_W];
  end

  rr_pick4 u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .win_oh_c  (win_oh_c),
    .win_idx_c (win_idx_c)
  );

  // Burst-completion qualifiers; an rlast seen before command accept finishes on accept.
  always_comb begin
    in_wait_c    = (state_q == ST_WAIT_CMD) || (state_q == ST_WAIT_DATA);
    rlast_beat_c = in_wait_c && axi_rvalid && axi_rlast;
    norm_fin_c   = ((state_q == ST_WAIT_CMD) && rd_done_p && (rlast_seen_q || rlast_beat_c)) ||
                   ((state_q == ST_WAIT_DATA) && rlast_beat_c);
    fin_c        = norm_fin_c || tmo_hit_c;
    mism_c       = rlast_beat_c &&
                   ((beat_q + BEAT_W'(1)) != (BEAT_W'(rd_len_q) + BEAT_W'(1)));
  end

`ifdef RD_ARB_TMO_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  assign tmo_hit_c = in_wait_c && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
  assign tmo_err   = tmo_err_q;

  // Watchdog: counts cycles spent waiting on the controller; the error is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) tmo_cnt_q <= '0;
      else if (in_wait_c)      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (tmo_hit_c && !norm_fin_c) tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign tmo_err   = 1'b0;
`endif

  // Arbiter FSM with registered command, grant and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      win_q          <= '0;
      last_q         <= PIDX_W'(NPORT_C - 1);
      gnt_q          <= '0;
      done_q         <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_len_q       <= '0;
      rd_id_q        <= '0;
      beat_q         <= '0;
      rlast_seen_q   <= 1'b0;
      len_mismatch_q <= 1'b0;
    end else begin
      rd_en_q        <= 1'b0;
      done_q         <= '0;
      len_mismatch_q <= len_mismatch_q | mism_c;
      if (in_wait_c && axi_rvalid) beat_q <= beat_q + BEAT_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            win_q   <= win_idx_c;
            gnt_q   <= win_oh_c;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rd_en_q      <= 1'b1;
          rd_addr_q    <= addr_a[win_q];
          rd_len_q     <= len_a[win_q];
          rd_id_q      <= ID_W'(win_q);
          beat_q       <= '0;
          rlast_seen_q <= 1'b0;
          state_q      <= ST_WAIT_CMD;
        end
        ST_WAIT_CMD: begin
          if (rlast_beat_c) rlast_seen_q <= 1'b1;
          if (rd_done_p)    state_q      <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (fin_c) begin
        done_q  <= gnt_q;
        gnt_q   <= '0;
        last_q  <= win_q;
        state_q <= ST_DONE;
      end
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign rd_len      = rd_len_q;
  assign rd_id       = rd_id_q;
  assign port_rvalid = {NPORT_C{axi_rvalid}} & gnt_q;

endmodule
